// File: rtl/ndmreset_sequencer.sv
// ndmreset_sequencer: turns power-on reset and the debug module's ndmreset
// request into an ordered release. Peripherals come out of reset first, then
// each hart in turn at a fixed stagger. Debug requests are masked for harts
// still in reset, and debugger-initiated resets are counted (saturating).
module ndmreset_sequencer #(
  parameter int NR_CORES       = 1,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                ndmreset,
  input  logic [NR_CORES-1:0] debug_req_irq_in,
  output logic [NR_CORES-1:0] debug_req_irq_out,
  output logic                periph_rst_n,
  output logic [NR_CORES-1:0] core_rst_n,
  output logic                busy,
  output logic [7:0]          ndmreset_count
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int IDX_W      = $clog2(NR_CORES + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_CORE    = IDX_W'(NR_CORES - 1);

  // REL_PERIPH is held back for a future peripheral-ack handshake; nothing
  // enters it today.
  typedef enum logic [1:0] {
    HOLD       = 2'd0,
    REL_PERIPH = 2'd1,
    REL_CORES  = 2'd2,
    RUN        = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [IDX_W-1:0]    core_idx, core_idx_next;
  logic                periph_next;
  logic [NR_CORES-1:0] core_next;
  logic [7:0]          count_next;

  // Next-state logic: hold-off counting, staggered core release, and
  // re-entry into HOLD on a debugger reset request.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    core_idx_next = core_idx;
    periph_next   = periph_rst_n;
    core_next     = core_rst_n;
    count_next    = ndmreset_count;

    if (ndmreset && (state == REL_CORES || state == RUN)) begin
      state_next    = HOLD;
      cnt_next      = '0;
      core_idx_next = '0;
      periph_next   = 1'b0;
      core_next     = '0;
      if (ndmreset_count != 8'hFF) begin
        count_next = ndmreset_count + 8'd1;
      end
    end else begin
      case (state)
        HOLD: begin
          periph_next = 1'b0;
          core_next   = '0;
          if (ndmreset) begin
            cnt_next = '0;
          end else if (cnt == HOLD_LAST) begin
            periph_next   = 1'b1;
            cnt_next      = '0;
            core_idx_next = '0;
            state_next    = REL_CORES;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        REL_CORES: begin
          if (cnt == STAGGER_LAST) begin
            for (int i = 0; i < NR_CORES; i++) begin
              if (core_idx == IDX_W'(i)) begin
                core_next[i] = 1'b1;
              end
            end
            core_idx_next = core_idx + IDX_W'(1);
            cnt_next      = '0;
            if (core_idx == LAST_CORE) begin
              state_next = RUN;
            end
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        RUN: begin
          periph_next = 1'b1;
        end
        default: begin
          state_next    = HOLD;
          cnt_next      = '0;
          core_idx_next = '0;
          periph_next   = 1'b0;
          core_next     = '0;
        end
      endcase
    end
  end

  // State, counters and registered reset outputs; aresetn overrides all.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state          <= HOLD;
      cnt            <= '0;
      core_idx       <= '0;
      periph_rst_n   <= 1'b0;
      core_rst_n     <= '0;
      ndmreset_count <= 8'd0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      core_idx       <= core_idx_next;
      periph_rst_n   <= periph_next;
      core_rst_n     <= core_next;
      ndmreset_count <= count_next;
    end
  end

  // Busy tracks the registered resets directly, so it drops on the edge
  // the last hart is released.
  always_comb begin
    busy = ~periph_rst_n | ~(&core_rst_n);
  end

  // Zero-latency gating: requests to a hart in reset are dropped.
  always_comb begin
    debug_req_irq_out = debug_req_irq_in & core_rst_n;
  end

endmodule
